// File: rtl/alu_cmd_issuer.sv
// Front-end sequencer: debounces a pushbutton and steps through operand/function
// entry for an attached ALU, then captures its result for display.
module alu_cmd_issuer #(
  parameter int N         = 3,
  parameter int DB_CYCLES = 250000,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic [N-1:0]     sw_data,
  input  logic [3:0]       sw_func,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_f,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_cout,
  input  logic             alu_ov,
  output logic [N-1:0]     res_y,
  output logic             res_c,
  output logic             res_ov,
  output logic             res_valid,
  output logic [2:0]       phase,
  output logic             f_err,
  output logic [CNT_W-1:0] op_count
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_F = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  logic            r_sync1, r_sync2, r_db, r_press;
  logic [DB_W-1:0] r_db_cnt;

  // Debounced level flips after DB_CYCLES consecutive differing samples;
  // the press pulse fires only when the old level was released (1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_db     <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
          r_press  <= r_db;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  state_t           r_state, w_state_next;
  logic [N-1:0]     r_alu_a, r_alu_b, w_alu_a_next, w_alu_b_next;
  logic [3:0]       r_alu_f, w_alu_f_next;
  logic [N-1:0]     r_res_y, w_res_y_next;
  logic             r_res_c, r_res_ov, r_res_valid, r_f_err;
  logic             w_res_c_next, w_res_ov_next, w_res_valid_next, w_f_err_next;
  logic [CNT_W-1:0] r_op_count, w_op_count_next;

  always_comb begin
    w_state_next     = r_state;
    w_alu_a_next     = r_alu_a;
    w_alu_b_next     = r_alu_b;
    w_alu_f_next     = r_alu_f;
    w_res_y_next     = r_res_y;
    w_res_c_next     = r_res_c;
    w_res_ov_next    = r_res_ov;
    w_res_valid_next = r_res_valid;
    w_f_err_next     = r_f_err;
    w_op_count_next  = r_op_count;
    case (r_state)
      LOAD_A: if (r_press) begin
        w_alu_a_next     = sw_data;
        w_res_valid_next = 1'b0;
        w_state_next     = LOAD_B;
      end
      LOAD_B: if (r_press) begin
        w_alu_b_next = sw_data;
        w_state_next = LOAD_F;
      end
      LOAD_F: if (r_press) begin
        // Codes 11xx are reserved: flag them and wait for a legal one.
        if (sw_func[3:2] == 2'b11) begin
          w_f_err_next = 1'b1;
        end else begin
          w_alu_f_next = sw_func;
          w_f_err_next = 1'b0;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_res_y_next     = alu_y;
        w_res_c_next     = alu_cout;
        w_res_ov_next    = alu_ov;
        w_res_valid_next = 1'b1;
        w_op_count_next  = r_op_count + CNT_W'(1);
        w_state_next     = SHOW;
      end
      SHOW: if (r_press) begin
        w_res_valid_next = 1'b0;
        w_state_next     = LOAD_A;
      end
      default: w_state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= LOAD_A;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_f     <= '0;
      r_res_y     <= '0;
      r_res_c     <= 1'b0;
      r_res_ov    <= 1'b0;
      r_res_valid <= 1'b0;
      r_f_err     <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_alu_a     <= w_alu_a_next;
      r_alu_b     <= w_alu_b_next;
      r_alu_f     <= w_alu_f_next;
      r_res_y     <= w_res_y_next;
      r_res_c     <= w_res_c_next;
      r_res_ov    <= w_res_ov_next;
      r_res_valid <= w_res_valid_next;
      r_f_err     <= w_f_err_next;
      r_op_count  <= w_op_count_next;
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_f     = r_alu_f;
  assign res_y     = r_res_y;
  assign res_c     = r_res_c;
  assign res_ov    = r_res_ov;
  assign res_valid = r_res_valid;
  assign phase     = r_state;
  assign f_err     = r_f_err;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed key/FSM scenarios, then random
// operations compared against a press-level behavioural model.
module tb_alu_cmd_issuer;
  localparam int N  = 3;
  localparam int DB = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_n = 1'b1;
  logic [N-1:0]  sw_data = '0;
  logic [3:0]    sw_func = '0;
  logic [N-1:0]  alu_a, alu_b, alu_y, res_y;
  logic [3:0]    alu_f;
  logic          alu_cout, alu_ov, res_c, res_ov, res_valid, f_err;
  logic [2:0]    phase;
  logic [CW-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.N(N), .DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw_data(sw_data), .sw_func(sw_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_cout(alu_cout),
    .alu_ov(alu_ov), .res_y(res_y), .res_c(res_c), .res_ov(res_ov),
    .res_valid(res_valid), .phase(phase), .f_err(f_err), .op_count(op_count)
  );

  // Reference ALU, returns {ov, cout, y}
  function automatic logic [N+1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] f);
    logic [N:0]   s;
    logic [N-1:0] y;
    logic         c, ov;
    s = '0; y = a; c = 1'b0; ov = 1'b0;
    case (f)
      4'b0000: begin
        s  = {1'b0, a} + {1'b0, b};
        y  = s[N-1:0]; c = s[N];
        ov = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      4'b0010: begin
        s  = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        y  = s[N-1:0]; c = s[N];
        ov = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      4'b0100: y = a & b;
      4'b0101: y = a | b;
      4'b0110: y = a ^ b;
      4'b0111: y = ~a;
      default: y = a;
    endcase
    return {ov, c, y};
  endfunction

  assign {alu_ov, alu_cout, alu_y} = ref_alu(alu_a, alu_b, alu_f);

  // Press-level model of the user-visible state
  int           m_phase, m_ops;
  logic [N-1:0] m_a, m_b, m_y;
  logic [3:0]   m_f;
  logic         m_c, m_ov, m_valid, m_ferr;

  task automatic model_reset();
    m_phase = 0; m_ops = 0; m_a = '0; m_b = '0; m_f = '0;
    m_y = '0; m_c = 1'b0; m_ov = 1'b0; m_valid = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic model_press(input logic [N-1:0] d, input logic [3:0] f);
    logic [N+1:0] r;
    case (m_phase)
      0: begin m_a = d; m_valid = 1'b0; m_phase = 1; end
      1: begin m_b = d; m_phase = 2; end
      2: begin
        if (f >= 4'd12) m_ferr = 1'b1;
        else begin
          m_f = f; m_ferr = 1'b0;
          r = ref_alu(m_a, m_b, m_f);
          {m_ov, m_c, m_y} = r;
          m_valid = 1'b1; m_ops++; m_phase = 4;
        end
      end
      default: begin m_valid = 1'b0; m_phase = 0; end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".phase"},     32'(phase),     32'(m_phase));
    check({tag, ".alu_a"},     32'(alu_a),     32'(m_a));
    check({tag, ".alu_b"},     32'(alu_b),     32'(m_b));
    check({tag, ".alu_f"},     32'(alu_f),     32'(m_f));
    check({tag, ".res_y"},     32'(res_y),     32'(m_y));
    check({tag, ".res_c"},     32'(res_c),     32'(m_c));
    check({tag, ".res_ov"},    32'(res_ov),    32'(m_ov));
    check({tag, ".res_valid"}, 32'(res_valid), 32'(m_valid));
    check({tag, ".f_err"},     32'(f_err),     32'(m_ferr));
    check({tag, ".op_count"},  32'(op_count),  32'(m_ops % (1 << CW)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full press: hold long enough to register, scramble switches on release
  task automatic press(input logic [N-1:0] d, input logic [3:0] f);
    sw_data = d; sw_func = f; key_n = 1'b0;
    repeat (8) tick();
    key_n = 1'b1;
    sw_data = N'($urandom); sw_func = 4'($urandom);
    model_press(d, f);
    repeat (8) tick();
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) tick();
    check_all("reset");
    rst_n = 1'b1;
    tick();

    // T1: press latency 2 + DB cycles, then FSM acts on the next edge
    sw_data = 3'd5; key_n = 1'b0;
    repeat (6) tick();
    check("t1.pre_phase", 32'(phase), 32'd0);
    tick();
    check("t1.phase", 32'(phase), 32'd1);
    check("t1.alu_a", 32'(alu_a), 32'd5);
    key_n = 1'b1;
    model_press(3'd5, 4'd0);
    repeat (8) tick();
    check_all("t1");

    // Reset while in EXEC discards the capture
    press(3'd1, 4'd0);
    sw_func = 4'b0000; key_n = 1'b0;
    repeat (7) tick();
    check("t6.exec_phase", 32'(phase), 32'd3);
    rst_n = 1'b0; key_n = 1'b1;
    tick();
    model_reset();
    check_all("t6.rst");
    rst_n = 1'b1;
    repeat (8) tick();

    // T2: 3 + 2
    press(3'd3, 4'd0); press(3'd2, 4'd0); press(3'd0, 4'b0000);
    check("t2.res_y", 32'(res_y), 32'd5);
    check("t2.res_ov", 32'(res_ov), 32'd1);
    check_all("t2");
    press(3'd0, 4'd0);
    check_all("t2.show");

    // T3: 2 - 3 with switches toggling during EXEC
    press(3'd2, 4'd0); press(3'd3, 4'd0);
    sw_func = 4'b0010; key_n = 1'b0;
    repeat (7) tick();
    check("t3.exec_phase", 32'(phase), 32'd3);
    sw_data = 3'd5; sw_func = 4'b1101;
    check("t3.exec_a", 32'(alu_a), 32'd2);
    check("t3.exec_b", 32'(alu_b), 32'd3);
    check("t3.exec_f", 32'(alu_f), 32'd2);
    tick();
    check("t3.show_phase", 32'(phase), 32'd4);
    check("t3.show_a", 32'(alu_a), 32'd2);
    check("t3.show_f", 32'(alu_f), 32'd2);
    check("t3.res_y", 32'(res_y), 32'd7);
    check("t3.res_c", 32'(res_c), 32'd0);
    key_n = 1'b1;
    model_press(3'd0, 4'b0010);
    repeat (8) tick();
    check_all("t3");
    press(3'd0, 4'd0);

    // T4: reserved code then legal code
    press(3'd1, 4'd0); press(3'd6, 4'd0);
    press(3'd0, 4'b1100);
    check("t4.rsv_phase", 32'(phase), 32'd2);
    check("t4.rsv_ferr", 32'(f_err), 32'd1);
    check_all("t4.rsv");
    press(3'd0, 4'b1011);
    check("t4.ok_ferr", 32'(f_err), 32'd0);
    check_all("t4.ok");
    press(3'd0, 4'd0);

    // T5: short glitch gives no press; long hold gives exactly one
    key_n = 1'b0;
    repeat (3) tick();
    key_n = 1'b1;
    repeat (10) tick();
    check_all("t5.glitch");
    sw_data = 3'd4; key_n = 1'b0;
    repeat (100) tick();
    check("t5.hold_phase", 32'(phase), 32'd1);
    key_n = 1'b1;
    model_press(3'd4, 4'd0);
    repeat (8) tick();
    check_all("t5.hold");

    // Random operations until the counter has wrapped
    guard = 0;
    while (m_ops < (1 << CW) && guard < 5000) begin
      press(N'($urandom), 4'($urandom));
      check_all("rand");
      guard++;
    end
    check("wrap.guard", 32'(m_ops), 32'(1 << CW));
    check("wrap.op_count", 32'(op_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Front-end sequencer that initiates operations on the N-bit ALU from board controls.
- Step-by-step operand and function entry: the user sets switches and presses a pushbutton to latch A, then B, then F.
- After F is latched it holds the operands stable for one execute cycle, then captures Y, Cout and OV into a result register for display.
- Sits between the board switch/key inputs and the ALU; drives the ALU operand and function ports and the display logic.

Parameters:
- N, 3: operand/result width; must match the attached ALU.
- DB_CYCLES, 250000: consecutive stable samples required to accept a key level change; 4 in simulation.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- key_n  in  1  raw pushbutton, active-low, asynchronous, bouncy
- sw_data  in  N  operand value switches
- sw_func  in  4  function code switches
- alu_a  out  N  registered operand A to ALU
- alu_b  out  N  registered operand B to ALU
- alu_f  out  4  registered function code to ALU
- alu_y  in  N  ALU result
- alu_cout  in  1  ALU carry out
- alu_ov  in  1  ALU overflow
- res_y  out  N  captured result
- res_c  out  1  captured carry
- res_ov  out  1  captured overflow
- res_valid  out  1  high while a captured result is current
- phase  out  3  state code for LED display
- f_err  out  1  sticky reserved-function flag
- op_count  out  CNT_W  completed operations, wraps

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low at a rising edge forces all of the following regardless of current state:
    - alu_a, alu_b, alu_f, res_y, res_c, res_ov, res_valid, f_err, op_count = 0
    - state = LOAD_A, phase = 0
    - sync and debounce registers = released (1), debounce counter = 0
- Key path:
  - key_n passes through a 2-flop synchronizer.
  - The debounced level changes only after DB_CYCLES consecutive samples differ from the current debounced level; any matching sample resets the counter.
  - A press event is a 1-cycle pulse on the debounced 1->0 transition. Release generates no event.
  - Latency from a clean key_n fall to the press pulse is 2 + DB_CYCLES cycles.
- FSM states (phase code): LOAD_A(0), LOAD_B(1), LOAD_F(2), EXEC(3), SHOW(4).
  - LOAD_A + press: alu_a <= sw_data; res_valid <= 0; go to LOAD_B.
  - LOAD_B + press: alu_b <= sw_data; go to LOAD_F.
  - LOAD_F + press with sw_func[3:2] == 2'b11 (reserved): stay in LOAD_F, f_err <= 1, alu_f unchanged.
  - LOAD_F + press with a legal code: alu_f <= sw_func; f_err <= 0; go to EXEC.
  - EXEC: lasts exactly one cycle; press is ignored. On exit: res_y <= alu_y, res_c <= alu_cout, res_ov <= alu_ov, res_valid <= 1, op_count <= op_count + 1 (mod 2^CNT_W); go to SHOW.
  - SHOW + press: go to LOAD_A with res_valid <= 0; res_y/res_c/res_ov keep their values.
- Hold rules:
  - alu_a/alu_b/alu_f change only on their own load press; they are stable throughout EXEC.
  - Switch changes outside a press have no effect.
- Boundaries:
  - op_count wraps from 2^CNT_W-1 to 0.
  - A reserved code followed by a legal code clears f_err on the legal press.
  - Reset during EXEC discards the capture and does not increment op_count.
  - A glitch shorter than DB_CYCLES produces no press.
  - A held key produces exactly one press.

Test Plan:
1. Reset, then DB_CYCLES=4 and a clean key press -> press pulse exactly 6 cycles after the key_n fall; phase 0->1; alu_a equals sw_data.
2. With a reference ALU attached (N=3): A=3, B=2, F=4'b0000 -> in SHOW res_y=5, res_c=0, res_ov=1, res_valid=1, op_count=1.
3. A=2, B=3, F=4'b0010 -> res_y=7, res_c=0; alu_a/alu_b/alu_f are unchanged during EXEC while the switches toggle.
4. In LOAD_F press with sw_func=4'b1100 -> phase stays 2 and f_err=1; then press with 4'b1011 -> f_err=0, phase advances 3->4.
5. key_n bounces low for 3 cycles then high -> no press and phase unchanged; key held low for 100 cycles -> exactly one press.
6. Assert rst_n low in EXEC -> next edge phase=0, op_count unchanged from its pre-operation value, and all result outputs are 0. Separately, with CNT_W=8, complete 256 operations -> op_count wraps to 0.
